div_unit: RTL

- Multi-cycle 32-bit signed/unsigned integer divider for the EX stage (DIV/DIVU).
- It is the requesting end of the pipeline stall protocol. It raises stallreq_o toward the pipeline controller while a division is in flight, and releases it when the result is ready.
- Implemented as a restoring divider, one quotient bit per cycle. Result format is {HI=remainder, LO=quotient}, written to HI/LO by later stages.

---
 rtl/div_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU), one quotient bit per cycle; result = {remainder, quotient}.
// Raises stallreq_o while start_i is held and the result is not yet ready.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int W     = DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_FREE, S_BY_ZERO, S_ON, S_END} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2*W:0]     work, work_n;
  logic [W-1:0]     divisor, divisor_n;
  logic             neg1, neg1_n;
  logic             neg2, neg2_n;
  logic             sdiv, sdiv_n;
  logic [2*W-1:0]   result_n;
  logic             ready_n;

  logic [W:0]       diff;
  logic [W-1:0]     mag1, mag2;
  logic [W-1:0]     quot_mag, rem_mag, quot, rem;

  assign stallreq_o = start_i & ~ready_o;

  // Magnitudes of the incoming operands, used only when loading in FREE
  assign mag1 = (signed_div_i && opdata1_i[W-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[W-1]) ? -opdata2_i : opdata2_i;

  // One-bit-wider subtract so a borrow shows up as diff[W]
  assign diff = {1'b0, work[2*W-1:W]} - {1'b0, divisor};

  assign quot_mag = work[W-1:0];
  assign rem_mag  = work[2*W:W+1];
  assign quot     = (sdiv && (neg1 ^ neg2)) ? -quot_mag : quot_mag;
  assign rem      = (sdiv && neg1)          ? -rem_mag  : rem_mag;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    work_n    = work;
    divisor_n = divisor;
    neg1_n    = neg1;
    neg2_n    = neg2;
    sdiv_n    = sdiv;
    result_n  = result_o;
    ready_n   = ready_o;

    case (state)
      S_FREE: begin
        ready_n  = 1'b0;
        result_n = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = S_BY_ZERO;
          end else begin
            state_n   = S_ON;
            cnt_n     = '0;
            work_n    = {{W{1'b0}}, mag1, 1'b0};
            divisor_n = mag2;
            neg1_n    = opdata1_i[W-1];
            neg2_n    = opdata2_i[W-1];
            sdiv_n    = signed_div_i;
          end
        end
      end

      S_BY_ZERO: begin
        state_n  = S_END;
        work_n   = '0;
        result_n = '0;
        ready_n  = 1'b1;
      end

      S_ON: begin
        if (annul_i) begin
          state_n = S_FREE;
          cnt_n   = '0;
          ready_n = 1'b0;
        end else if (cnt != CNT_W'(DATA_W)) begin
          if (diff[W])
            work_n = {work[2*W-1:0], 1'b0};
          else
            work_n = {diff[W-1:0], work[W-1:0], 1'b1};
          cnt_n = cnt + 1'b1;
        end else begin
          state_n  = S_END;
          result_n = {rem, quot};
          ready_n  = 1'b1;
          cnt_n    = '0;
        end
      end

      S_END: begin
        // Result is held until EX retires the instruction; flushes cannot cancel it here
        if (!start_i) begin
          state_n  = S_FREE;
          ready_n  = 1'b0;
          result_n = '0;
        end
      end

      default: state_n = S_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      sdiv     <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      work     <= work_n;
      divisor  <= divisor_n;
      neg1     <= neg1_n;
      neg2     <= neg2_n;
      sdiv     <= sdiv_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule
